// File: rtl/ibex_pkg.sv
// Shared definitions for the fetch aligner slice.
//   fetch_align_state_e : aligner FSM states (ALIGNED, UNALIGNED, HALF)
//   BOOT_ADDR           : PC after reset, before any redirect
//   OPCODE_*            : RV32 major opcodes used by the compressed expander
//   isCompressed()      : true when the two low instruction bits mark a 16-bit encoding
package ibex_pkg;

    typedef enum logic [1:0] {
        ALIGNED   = 2'd0,
        UNALIGNED = 2'd1,
        HALF      = 2'd2
    } fetch_align_state_e;

    localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;

    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_JAL    = 7'h6f;

    function automatic logic isCompressed(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_aligner_if.sv
// Bus bundle between the prefetch buffer, the fetch aligner and the ID stage.
//   fetch_valid/fetch_ready/fetch_rdata/fetch_err : word-aligned fetch words in
//   out_valid/out_ready/out_instr/out_addr/out_is_compressed/out_illegal_c/out_err
//                                                 : one-entry instruction slot out
// Modports: slave = the aligner, master = the environment around it.
interface ibex_fetch_aligner_if;

    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        fetch_err;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_is_compressed;
    logic        out_illegal_c;
    logic        out_err;

    modport slave (
        input  fetch_valid, fetch_rdata, fetch_err, out_ready,
        output fetch_ready, out_valid, out_instr, out_addr,
               out_is_compressed, out_illegal_c, out_err
    );

    modport master (
        output fetch_valid, fetch_rdata, fetch_err, out_ready,
        input  fetch_ready, out_valid, out_instr, out_addr,
               out_is_compressed, out_illegal_c, out_err
    );

endinterface

// File: rtl/ibex_compressed_decoder.sv
// RV32C expander fed with the aligner's selected 32-bit candidate word.
//   instr_i   : candidate word (compressed when instr_i[1:0] != 2'b11)
//   instr_o   : 32-bit equivalent, or the word unchanged for 32-bit encodings
//   illegal_o : compressed encoding is reserved/illegal
// Build option IBEX_FETCH_ALIGNER_CDEC_EN: when defined, compressed instructions
// are expanded; otherwise they pass as the raw halfword zero-extended and
// illegal_o stays 0.
module ibex_compressed_decoder
    import ibex_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    // Purely combinational expansion, 32-bit encodings fall through untouched
    always_comb begin
        instr_o   = instr_i;
        illegal_o = 1'b0;
`ifdef IBEX_FETCH_ALIGNER_CDEC_EN
        case (instr_i[1:0])
            2'b00: begin
                case (instr_i[15:13])
                    3'b000: begin
                        // c.addi4spn, an all-zero immediate is reserved
                        instr_o = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                                   5'd2, 3'b000, 2'b01, instr_i[4:2], OPCODE_OP_IMM};
                        illegal_o = (instr_i[12:5] == 8'h00);
                    end
                    3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01,
                                       instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
                    3'b110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01,
                                       instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE};
                    default: illegal_o = 1'b1;
                endcase
            end
            2'b01: begin
                case (instr_i[15:13])
                    3'b000: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b000,
                                       instr_i[11:7], OPCODE_OP_IMM};
                    3'b001, 3'b101: begin
                        // c.jal links to x1, c.j to x0; bit 15 tells them apart
                        instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7], instr_i[2],
                                   instr_i[11], instr_i[5:3], {9{instr_i[12]}}, 4'b0, ~instr_i[15], OPCODE_JAL};
                    end
                    3'b010: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b000,
                                       instr_i[11:7], OPCODE_OP_IMM};
                    3'b011: begin
                        // rd == x2 selects c.addi16sp, anything else is c.lui
                        if (instr_i[11:7] == 5'd2) begin
                            instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0,
                                       5'd2, 3'b000, 5'd2, OPCODE_OP_IMM};
                        end else begin
                            instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
                        end
                        illegal_o = ({instr_i[12], instr_i[6:2]} == 6'b0);
                    end
                    3'b100: begin
                        case (instr_i[11:10])
                            2'b00, 2'b01: begin
                                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7], 3'b101,
                                           2'b01, instr_i[9:7], OPCODE_OP_IMM};
                                illegal_o = instr_i[12];
                            end
                            2'b10: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                                              3'b111, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
                            default: begin
                                // c.sub/c.xor/c.or/c.and; funct3 follows from bits 6:5
                                instr_o = {1'b0, (instr_i[6:5] == 2'b00), 5'b0, 2'b01, instr_i[4:2], 2'b01,
                                           instr_i[9:7], 3'b000, 2'b01, instr_i[9:7], OPCODE_OP};
                                case (instr_i[6:5])
                                    2'b01:   instr_o[14:12] = 3'b100;
                                    2'b10:   instr_o[14:12] = 3'b110;
                                    2'b11:   instr_o[14:12] = 3'b111;
                                    default: instr_o[14:12] = 3'b000;
                                endcase
                                illegal_o = instr_i[12];
                            end
                        endcase
                    end
                    default: instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                                        2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12], OPCODE_BRANCH};
                endcase
            end
            2'b10: begin
                case (instr_i[15:13])
                    3'b000: begin
                        instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OP_IMM};
                        illegal_o = instr_i[12];
                    end
                    3'b010: begin
                        instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'd2, 3'b010,
                                   instr_i[11:7], OPCODE_LOAD};
                        illegal_o = (instr_i[11:7] == 5'd0);
                    end
                    3'b100: begin
                        // c.jr / c.mv / c.ebreak / c.jalr / c.add share this slot
                        if (instr_i[6:2] != 5'd0) begin
                            instr_o = {7'b0, instr_i[6:2], (instr_i[12] ? instr_i[11:7] : 5'd0), 3'b000,
                                       instr_i[11:7], OPCODE_OP};
                        end else if (instr_i[12] && instr_i[11:7] == 5'd0) begin
                            instr_o = 32'h0010_0073;
                        end else begin
                            instr_o = {12'b0, instr_i[11:7], 3'b000, 4'b0, instr_i[12], OPCODE_JALR};
                            illegal_o = !instr_i[12] && (instr_i[11:7] == 5'd0);
                        end
                    end
                    3'b110: instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'd2, 3'b010,
                                       instr_i[11:9], 2'b00, OPCODE_STORE};
                    default: illegal_o = 1'b1;
                endcase
            end
            default: ;
        endcase
`else
        if (isCompressed(instr_i[1:0])) begin
            instr_o = {16'h0000, instr_i[15:0]};
        end
`endif
    end

endmodule

// File: rtl/ibex_fetch_aligner.sv
// Instruction-stream aligner between the prefetch buffer and ID. Splits word-aligned
// fetch words into 16/32-bit instructions (including words-straddling ones), tracks
// the PC and registers each instruction into a one-entry output slot.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   branch_i, branch_addr_i : redirect pulse and target (bit 0 ignored)
//   bus (slave)             : fetch word input and instruction slot output
// Build option IBEX_FETCH_ALIGNER_CDEC_EN enables compressed-instruction expansion
// inside ibex_compressed_decoder.
module ibex_fetch_aligner
    import ibex_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        branch_i,
    input  logic [31:0]                 branch_addr_i,
    ibex_fetch_aligner_if.slave         bus
);

    fetch_align_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_err_q, hold_err_d;

    logic        out_valid_q;
    logic [31:0] out_instr_q, out_addr_q;
    logic        out_is_c_q, out_ill_q, out_err_q;

    logic        slotFree, fetchAccept, emit, candErr, candCompressed;
    logic [31:0] candWord, decInstr;
    logic        decIllegal;

    // A fetch word is only taken when there is somewhere to put its first instruction;
    // a compressed hold needs no new word, so HALF stalls the fetch side then.
    assign slotFree        = !out_valid_q || bus.out_ready;
    assign bus.fetch_ready = !branch_i && slotFree && (state_q != HALF || !isCompressed(hold_q[1:0]));
    assign fetchAccept     = bus.fetch_valid && bus.fetch_ready;

    ibex_compressed_decoder u_cdec (
        .instr_i   (candWord),
        .instr_o   (decInstr),
        .illegal_o (decIllegal)
    );

    // Next-state logic: picks the candidate instruction and advances PC/hold/state
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_d         = hold_q;
        hold_err_d     = hold_err_q;
        emit           = 1'b0;
        candWord       = bus.fetch_rdata;
        candErr        = bus.fetch_err;
        candCompressed = 1'b0;
        if (branch_i) begin
            state_d    = branch_addr_i[1] ? UNALIGNED : ALIGNED;
            pc_d       = branch_addr_i & 32'hFFFF_FFFE;
            hold_d     = '0;
            hold_err_d = 1'b0;
        end else begin
            case (state_q)
                ALIGNED: begin
                    if (fetchAccept) begin
                        emit = 1'b1;
                        if (isCompressed(bus.fetch_rdata[1:0])) begin
                            candCompressed = 1'b1;
                            pc_d           = pc_q + 32'd2;
                            hold_d         = bus.fetch_rdata[31:16];
                            hold_err_d     = bus.fetch_err;
                            state_d        = HALF;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                UNALIGNED: begin
                    if (fetchAccept) begin
                        hold_d     = bus.fetch_rdata[31:16];
                        hold_err_d = bus.fetch_err;
                        state_d    = HALF;
                    end
                end
                HALF: begin
                    if (isCompressed(hold_q[1:0])) begin
                        if (slotFree) begin
                            emit           = 1'b1;
                            candWord       = {16'h0000, hold_q};
                            candErr        = hold_err_q;
                            candCompressed = 1'b1;
                            pc_d           = pc_q + 32'd2;
                            state_d        = ALIGNED;
                        end
                    end else if (fetchAccept) begin
                        // Straddling 32-bit instruction: upper half comes from the new word
                        emit       = 1'b1;
                        candWord   = {bus.fetch_rdata[15:0], hold_q};
                        candErr    = hold_err_q | bus.fetch_err;
                        pc_d       = pc_q + 32'd4;
                        hold_d     = bus.fetch_rdata[31:16];
                        hold_err_d = bus.fetch_err;
                    end
                end
                default: state_d = ALIGNED;
            endcase
        end
    end

    // Alignment state, PC and hold register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ALIGNED;
            pc_q       <= BOOT_ADDR;
            hold_q     <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            hold_err_q <= hold_err_d;
        end
    end

    // Output slot: loads on emission, empties on acceptance, flushed by redirect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_is_c_q  <= 1'b0;
            out_ill_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (branch_i) begin
            out_valid_q <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_instr_q <= decInstr;
            out_addr_q  <= pc_q;
            out_is_c_q  <= candCompressed;
            out_ill_q   <= candCompressed & decIllegal;
            out_err_q   <= candErr;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_instr         = out_instr_q;
    assign bus.out_addr          = out_addr_q;
    assign bus.out_is_compressed = out_is_c_q;
    assign bus.out_illegal_c     = out_ill_q;
    assign bus.out_err           = out_err_q;

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// Self-checking bench for ibex_fetch_aligner: a vector table of fetch words with their
// expected emissions, plus hand-written straddle, wrap, backpressure/redirect and
// mid-operation reset sequences. Expected instructions are queued when a word is
// driven and compared when the slot is handed to ID.
module tb_ibex_fetch_aligner;
    import ibex_pkg::*;

`ifdef IBEX_FETCH_ALIGNER_CDEC_EN
    localparam bit CDEC = 1'b1;
`else
    localparam bit CDEC = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        isC;
        logic        ill;
        logic        err;
        logic        chkInstr;
    } expT;

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          nEmit;
        expT         e0;
        expT         e1;
    } vecT;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [31:0] branchAddr;
    int          nChecks = 0;
    int          nFails  = 0;
    expT         sbQ[$];
    vecT         tbl[5];

    ibex_fetch_aligner_if bus();

    ibex_fetch_aligner dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .branch_i      (branch),
        .branch_addr_i (branchAddr),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected instruction word for a compressed halfword in the current build
    function automatic logic [31:0] cInstr(input logic [15:0] raw, input logic [31:0] expanded);
        return CDEC ? expanded : {16'h0000, raw};
    endfunction

    function automatic expT mkExp(input logic [31:0] instr, input logic [31:0] addr, input logic isC,
                                  input logic ill, input logic err, input logic chk);
        expT e;
        e.instr = instr; e.addr = addr; e.isC = isC;
        e.ill = CDEC & ill; e.err = err; e.chkInstr = chk;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one fetch word until the aligner takes it (bounded)
    task automatic applyStimulus(input logic [31:0] word, input logic err);
        bit accepted;
        accepted        = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_rdata = word;
        bus.fetch_err   = err;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.fetch_ready;
            @(posedge clk); #1;
        end
        bus.fetch_valid = 1'b0;
        bus.fetch_err   = 1'b0;
        if (!accepted) begin
            nChecks++; nFails++;
            $display("[TB] FAIL fetch_accept_timeout: got no accept of 0x%08h expected accept", word);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && sbQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic doBranch(input logic [31:0] addr);
        branch     = 1'b1;
        branchAddr = addr;
        @(posedge clk); #1;
        branch     = 1'b0;
    endtask

    // Scoreboard side: every handshake out of the slot is matched against the queue
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++; nFails++;
                $display("[TB] FAIL unexpected_output: got 0x%08h @0x%08h expected none",
                         bus.out_instr, bus.out_addr);
            end else begin
                expT e;
                e = sbQ.pop_front();
                if (e.chkInstr) checkOutput("out_instr", bus.out_instr, e.instr);
                checkOutput("out_addr", bus.out_addr, e.addr);
                checkOutput("out_is_compressed", 32'(bus.out_is_compressed), 32'(e.isC));
                checkOutput("out_illegal_c", 32'(bus.out_illegal_c), 32'(e.ill));
                checkOutput("out_err", 32'(bus.out_err), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        branch          = 1'b0;
        branchAddr      = '0;
        bus.fetch_valid = 1'b0;
        bus.fetch_rdata = '0;
        bus.fetch_err   = 1'b0;
        bus.out_ready   = 1'b1;

        tbl[0] = '{32'h00A00513, 1'b0, 1, mkExp(32'h00A00513, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1),
                   mkExp(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{32'h45050505, 1'b0, 2, mkExp(cInstr(16'h0505, 32'h00150513), 32'h84, 1'b1, 1'b0, 1'b0, 1'b1),
                   mkExp(cInstr(16'h4505, 32'h00100513), 32'h86, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[2] = '{32'h852A0505, 1'b1, 2, mkExp(cInstr(16'h0505, 32'h00150513), 32'h88, 1'b1, 1'b0, 1'b1, 1'b1),
                   mkExp(cInstr(16'h852A, 32'h00A00533), 32'h8A, 1'b1, 1'b0, 1'b1, 1'b1)};
        tbl[3] = '{32'h00010000, 1'b0, 2, mkExp(32'h0, 32'h8C, 1'b1, 1'b1, 1'b0, !CDEC),
                   mkExp(cInstr(16'h0001, 32'h00000013), 32'h8E, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[4] = '{32'hFFFFFFFF, 1'b1, 1, mkExp(32'hFFFFFFFF, 32'h90, 1'b0, 1'b0, 1'b1, 1'b1),
                   mkExp(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0)};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state with no fetch word offered
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("reset_fetch_ready", 32'(bus.fetch_ready), 32'h1);
        checkOutput("reset_out_instr", bus.out_instr, 32'h0);
        checkOutput("reset_out_addr", bus.out_addr, 32'h0);
        checkOutput("reset_flags", {29'b0, bus.out_is_compressed, bus.out_illegal_c, bus.out_err}, 32'h0);
        @(posedge clk); #1;

        // Vector table: aligned words, one or two instructions each
        for (int v = 0; v < 5; v++) begin
            sbQ.push_back(tbl[v].e0);
            if (tbl[v].nEmit == 2) sbQ.push_back(tbl[v].e1);
            applyStimulus(tbl[v].word, tbl[v].err);
            if (tbl[v].nEmit == 2) begin
                @(negedge clk);
                checkOutput("half_fetch_ready", 32'(bus.fetch_ready), 32'h0);
                @(posedge clk); #1;
            end
        end
        waitDrain();

        // Straddling instruction after an unaligned redirect, without and with error
        for (int e = 0; e < 2; e++) begin
            doBranch(32'h0000_0102);
            sbQ.push_back(mkExp(32'h00500513, 32'h102, 1'b0, 1'b0, e[0], 1'b1));
            sbQ.push_back(mkExp(cInstr(16'h1234, 32'h12810693), 32'h106, 1'b1, 1'b0, e[0], 1'b1));
            applyStimulus(32'h05130000, 1'b0);
            applyStimulus(32'h12340050, e[0]);
            waitDrain();
        end

        // PC wrap with an odd redirect target
        doBranch(32'hFFFF_FFFD);
        sbQ.push_back(mkExp(32'h00A00513, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(32'h00A00513, 1'b0);
        sbQ.push_back(mkExp(cInstr(16'h0505, 32'h00150513), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
        sbQ.push_back(mkExp(cInstr(16'h4505, 32'h00100513), 32'h2, 1'b1, 1'b0, 1'b0, 1'b1));
        applyStimulus(32'h45050505, 1'b0);
        waitDrain();

        // Backpressure holds the slot, then a redirect drops it and the pending hold
        bus.out_ready = 1'b0;
        applyStimulus(32'h45050505, 1'b0);
        bus.fetch_valid = 1'b1;
        bus.fetch_rdata = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'h1);
            checkOutput("bp_out_instr", bus.out_instr, cInstr(16'h0505, 32'h00150513));
            checkOutput("bp_out_addr", bus.out_addr, 32'h4);
            checkOutput("bp_fetch_ready", 32'(bus.fetch_ready), 32'h0);
            @(posedge clk); #1;
        end
        doBranch(32'h0000_0200);
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        checkOutput("redirect_out_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        sbQ.push_back(mkExp(32'h00A00513, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(32'h00A00513, 1'b0);
        waitDrain();

        // Asynchronous reset with a full slot returns to boot state
        bus.out_ready = 1'b0;
        applyStimulus(32'h00A00513, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("async_reset_out_instr", bus.out_instr, 32'h0);
        checkOutput("async_reset_out_addr", bus.out_addr, 32'h0);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        sbQ.push_back(mkExp(32'h00A00513, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(32'h00A00513, 1'b0);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ibex_fetch_aligner.md
# ibex_fetch_aligner

Instruction-stream aligner between the prefetch buffer and the ID stage. Accepts 32-bit word-aligned fetch words and emits one instruction per handshake. Handles mixed 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two fetch words, and tracks the instruction PC. Compressed instructions are optionally expanded to their 32-bit equivalents before being registered into a one-entry output slot.

## Interface
- BOOT_ADDR, 32'h0000_0080: PC after reset, before any redirect.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- branch_i  in  1  redirect/flush pulse.
- branch_addr_i  in  32  redirect target. Bit 0 is ignored.
- fetch_valid_i  in  1  fetch word available.
- fetch_ready_o  out  1  fetch word consumed this cycle.
- fetch_rdata_i  in  32  fetch word, word-aligned.
- fetch_err_i  in  1  bus error on this word.
- out_valid_o  out  1  instruction slot full.
- out_ready_i  in  1  ID accepts the slot.
- out_instr_o  out  32  instruction (expanded when decode is enabled).
- out_addr_o  out  32  PC of the instruction.
- out_is_compressed_o  out  1  instruction was 16-bit.
- out_illegal_c_o  out  1  illegal compressed encoding.
- out_err_o  out  1  fetch error on any half used.

## Operation
- State: ALIGNED (next instruction starts at word bit 0), UNALIGNED (next instruction starts at word bit 16; the lower half is discarded), HALF (16-bit hold register `hold_q` plus `hold_err_q` is valid).
- Slot free: `!out_valid_o || out_ready_i`. A free slot is required for any progress except redirect.
- ALIGNED, word W accepted:
  - W[1:0]!=11: emit W[15:0] at PC, PC+=2, latch W[31:16] into hold, go to HALF.
  - W[1:0]==11: emit W at PC, PC+=4, stay in ALIGNED.
- UNALIGNED, word W accepted: latch W[31:16] into hold, go to HALF. No emission that cycle.
- HALF, hold H:
  - H[1:0]!=11: emit H at PC, PC+=2, go to ALIGNED. No fetch word is consumed; fetch_ready_o=0.
  - H[1:0]==11: wait for word W. Emit {W[15:0],H}, PC+=4, latch W[31:16], stay in HALF.
- fetch_ready_o (combinational) = `!branch_i && slot free && (state!=HALF || hold_q[1:0]==11)`.
- out_err_o = OR of the error bits of every half used. For a straddling instruction this is `hold_err_q | fetch_err_i`.
- PC arithmetic is 32-bit and wraps modulo 2^32. out_addr_o is the PC before increment.
- Redirect: branch_i has priority over everything.
  - Next cycle: out_valid_o=0, hold invalid, PC=branch_addr_i & ~1.
  - State becomes UNALIGNED if branch_addr_i[1] is set, otherwise ALIGNED.
  - The fetch word in the same cycle is not consumed.

## Timing
- Reset values: out_valid_o=0, out_instr_o=0, out_addr_o=0, out_is_compressed_o=0, out_illegal_c_o=0, out_err_o=0. PC=BOOT_ADDR, state=ALIGNED, hold_q=0.
- Latency: fetch accept at edge N gives out_valid_o=1 after edge N+1 (registered slot).
- Throughput: one instruction per cycle with out_ready_i=1. A word holding two RVC instructions takes 2 cycles; its second cycle has fetch_ready_o=0.
- Slot outputs hold stable while `out_valid_o && !out_ready_i`.
- Handshake into the slot happens on fetch_valid_i && fetch_ready_o, or on a HALF compressed emission with the slot free.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The pending hold is discarded.

## Configuration
- IBEX_FETCH_ALIGNER_CDEC_EN defined:
  - out_instr_o carries the 32-bit expansion of compressed instructions.
  - out_illegal_c_o is driven by the decoder.
  - 32-bit instructions pass through unchanged.
- Undefined:
  - out_instr_o carries the raw halfword zero-extended to 32 bits for compressed instructions.
  - out_illegal_c_o is tied to 0.
  - Alignment behaviour is identical.

## Structure
- Shared package ibex_pkg holds `fetch_align_state_e` (ALIGNED, UNALIGNED, HALF) and the OPCODE constants used for checks.
- One sub-module: ibex_compressed_decoder, instantiated under the macro and fed with the selected 32-bit candidate word.
- Everything else (state FSM, hold register, PC, output slot) lives in this module.

## Test plan
- Reset release with fetch_valid_i=0:
  - out_valid_o=0, fetch_ready_o=1, first emitted out_addr_o=0x80.
- Word 0x00A00513:
  - Next cycle out_instr_o=0x00A00513, addr 0x80, out_is_compressed_o=0. PC becomes 0x84.
- Word 0x45050505 with macro enabled:
  - Cycle 1 emits 0x00150513 @0x80, compressed=1.
  - Cycle 2 emits 0x00100513 @0x82 with fetch_ready_o=0.
- Straddle: branch to 0x102, then words 0x05130000 and 0x12340050:
  - Emits 0x00500513 @0x102.
  - Then the compressed 0x1234 expansion @0x106.
- Straddle error: same as above with fetch_err_i=1 on the second word only:
  - out_err_o=1 on the straddling instruction.
  - out_err_o=1 on the following compressed instruction (its half came from the errored word).
- Backpressure then redirect:
  - out_ready_i=0 for 3 cycles: slot stable, fetch_ready_o=0.
  - branch_i to 0x200 in HALF: next cycle out_valid_o=0, the next emitted address is 0x200, and the old hold never appears.
